// File: rtl/sparse_cnn_pkg.sv
// sparse_cnn_pkg: shared sizes, FSM state and data types for the sparse
// convolution engine. No ports; imported by sparse_cnn and sparse_cnn_mac.
package sparse_cnn_pkg;

    localparam int WORD_LENGTH = 8;
    localparam int IMAGE_SIZE  = 28;
    localparam int KERNEL_SIZE = 5;
    localparam int OUT_SIZE    = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int ACC_WIDTH   = 16;
    localparam int MAX_ENTRIES = 28;
    localparam int MAX_NV      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NUM_PIX     = IMAGE_SIZE * IMAGE_SIZE;
    localparam int NUM_OUT     = OUT_SIZE * OUT_SIZE;

    typedef enum logic [1:0] {
        LOAD,
        SCAN,
        MAC,
        DONE
    } state_t;

    typedef logic signed [WORD_LENGTH-1:0] pixel_t;
    typedef logic signed [ACC_WIDTH-1:0]   acc_t;

endpackage

// File: rtl/sparse_cnn_mac.sv
// sparse_cnn_mac: scatter target for one pixel/kernel-entry pair plus product.
// Ports: px/py pixel position, dx/dy entry offsets, pixel/weight operands;
// hit = target inside the output map, idx = flat target index, prod = pixel*weight.
module sparse_cnn_mac
    import sparse_cnn_pkg::*;
(
    input  logic [4:0]             px,
    input  logic [4:0]             py,
    input  logic [WORD_LENGTH-1:0] dx,
    input  logic [WORD_LENGTH-1:0] dy,
    input  pixel_t                 pixel,
    input  pixel_t                 weight,
    output logic                   hit,
    output logic [9:0]             idx,
    output acc_t                   prod
);

    logic [9:0] oy;
    logic [9:0] ox;

    // 10-bit difference: a negative target wraps to >= 512, so a single
    // unsigned compare rejects both negative and too-large targets.
    assign oy = {5'd0, py} - {2'd0, dy};
    assign ox = {5'd0, px} - {2'd0, dx};

    assign hit  = (oy < 10'(OUT_SIZE)) && (ox < 10'(OUT_SIZE));
    assign idx  = oy * 10'(OUT_SIZE) + ox;
    assign prod = ACC_WIDTH'(pixel) * ACC_WIDTH'(weight);

endmodule

// File: rtl/sparse_cnn.sv
// sparse_cnn: buffers a 28x28 signed image, then scatter-accumulates every
// pixel through up to 25 sparse kernel entries into a 24x24 16-bit map.
// Ports: clk/rst (async high), tclk (unused), feature_in_valid/in_feature
// pixel stream, pe_input_weight_value/rows/cols packed entries (8 bits each),
// weight_valid_num entry count, out_valid level, out_feature flat result.
// Build option SPARSE_ZERO_SKIP_EN: zero pixels skip their MAC cycles.
module sparse_cnn
    import sparse_cnn_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tclk,
    input  logic                               feature_in_valid,
    input  logic [WORD_LENGTH-1:0]             in_feature,
    input  logic [MAX_ENTRIES*WORD_LENGTH-1:0] pe_input_weight_value,
    input  logic [MAX_ENTRIES*WORD_LENGTH-1:0] pe_input_weight_rows,
    input  logic [MAX_ENTRIES*WORD_LENGTH-1:0] pe_input_weight_cols,
    input  logic [15:0]                        weight_valid_num,
    output logic                               out_valid,
    output logic [NUM_OUT*ACC_WIDTH-1:0]       out_feature
);

    state_t state;
    logic [9:0] cnt;
    logic [9:0] p;
    logic [4:0] px;
    logic [4:0] py;
    logic [4:0] k;
    logic [4:0] nv;

    pixel_t image [NUM_PIX];
    acc_t   acc   [NUM_OUT];

    pixel_t pix;
    pixel_t w;
    logic [WORD_LENGTH-1:0] dx;
    logic [WORD_LENGTH-1:0] dy;
    logic       skip;
    logic       p_last;
    logic       k_last;
    logic       adv;
    logic       hit;
    logic [9:0] idx;
    acc_t       prod;
    logic       unused_tclk;

    assign unused_tclk = tclk;

    assign pix = image[p];
    assign w   = pe_input_weight_value[{k, 3'b000} +: WORD_LENGTH];
    assign dx  = pe_input_weight_rows[{k, 3'b000} +: WORD_LENGTH];
    assign dy  = pe_input_weight_cols[{k, 3'b000} +: WORD_LENGTH];

`ifdef SPARSE_ZERO_SKIP_EN
    assign skip = (pix == '0) || (nv == '0);
`else
    assign skip = (nv == '0);
`endif

    assign p_last = (p == 10'(NUM_PIX - 1));
    assign k_last = (k == nv - 5'd1);
    // Current pixel is finished this cycle.
    assign adv = ((state == SCAN) && skip) || ((state == MAC) && k_last);

    sparse_cnn_mac u_mac (
        .px     (px),
        .py     (py),
        .dx     (dx),
        .dy     (dy),
        .pixel  (pix),
        .weight (w),
        .hit    (hit),
        .idx    (idx),
        .prod   (prod)
    );

    always_ff @(posedge clk) begin
        if (state == LOAD && feature_in_valid) begin
            image[cnt] <= in_feature;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                acc[i] <= '0;
            end
        end else if (state == MAC && hit) begin
            acc[idx] <= acc[idx] + prod;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= '0;
            p         <= '0;
            px        <= '0;
            py        <= '0;
            k         <= '0;
            nv        <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (feature_in_valid) begin
                        cnt <= cnt + 10'd1;
                        if (cnt == 10'(NUM_PIX - 1)) begin
                            nv <= (weight_valid_num > 16'(MAX_NV)) ?
                                  5'(MAX_NV) : weight_valid_num[4:0];
                            p     <= '0;
                            px    <= '0;
                            py    <= '0;
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (!skip) begin
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    k <= k + 5'd1;
                    if (k_last) begin
                        state <= SCAN;
                    end
                end
                DONE: begin
                    out_valid <= 1'b1;
                end
            endcase
            // Pixel advance overrides the SCAN return on the final pixel.
            if (adv) begin
                if (p_last) begin
                    state <= DONE;
                end else begin
                    p <= p + 10'd1;
                    if (px == 5'(IMAGE_SIZE - 1)) begin
                        px <= '0;
                        py <= py + 5'd1;
                    end else begin
                        px <= px + 5'd1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_feature[g*ACC_WIDTH +: ACC_WIDTH] = acc[g];
    end

endmodule

// File: tb/tb_sparse_cnn.sv
// tb_sparse_cnn: randomized self-checking bench for sparse_cnn against a
// gather-form convolution model and a per-pixel cycle-cost latency model.
module tb_sparse_cnn;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tclk = 1'b0;
    logic          feature_in_valid = 1'b0;
    logic [7:0]    in_feature = '0;
    logic [223:0]  wval = '0;
    logic [223:0]  wrow = '0;
    logic [223:0]  wcol = '0;
    logic [15:0]   wvn = '0;
    logic          out_valid;
    logic [9215:0] out_feature;

    int img [784];
    int kv  [28];
    int kdx [28];
    int kdy [28];
    int nreq;
    logic [15:0] expv [576];
    int total = 0;
    int bad = 0;
    int lat;

    always #5 clk = ~clk;

    sparse_cnn dut (
        .clk                   (clk),
        .rst                   (rst),
        .tclk                  (tclk),
        .feature_in_valid      (feature_in_valid),
        .in_feature            (in_feature),
        .pe_input_weight_value (wval),
        .pe_input_weight_rows  (wrow),
        .pe_input_weight_cols  (wcol),
        .weight_valid_num      (wvn),
        .out_valid             (out_valid),
        .out_feature           (out_feature)
    );

    task automatic drive_weights();
        for (int k = 0; k < 28; k++) begin
            wval[8*k +: 8] = 8'(kv[k]);
            wrow[8*k +: 8] = 8'(kdx[k]);
            wcol[8*k +: 8] = 8'(kdy[k]);
        end
        wvn = 16'(nreq);
    endtask

    // out[oy][ox] = sum_k w_k * image[oy+dy_k][ox+dx_k], mod 2^16
    task automatic model();
        int n;
        n = (nreq > 25) ? 25 : nreq;
        for (int oy = 0; oy < 24; oy++) begin
            for (int ox = 0; ox < 24; ox++) begin
                int s;
                s = 0;
                for (int k = 0; k < n; k++) begin
                    int y;
                    int x;
                    y = oy + kdy[k];
                    x = ox + kdx[k];
                    if (y < 28 && x < 28) s += kv[k] * img[y*28 + x];
                end
                expv[oy*24 + ox] = 16'(s);
            end
        end
    endtask

    // Cycles from the last captured pixel to out_valid.
    function automatic int exp_latency();
        int n;
        int c;
        n = (nreq > 25) ? 25 : nreq;
        c = 0;
        for (int i = 0; i < 784; i++) begin
            if (n == 0) c += 1;
`ifdef SPARSE_ZERO_SKIP_EN
            else if (img[i] == 0) c += 1;
`endif
            else c += 1 + n;
        end
        return c + 1;
    endfunction

    task automatic set_raster();
        for (int k = 0; k < 28; k++) begin
            kdx[k] = k % 5;
            kdy[k] = k / 5;
            kv[k]  = 0;
        end
    endtask

    task automatic fill_img(input int v);
        for (int i = 0; i < 784; i++) img[i] = v;
    endtask

    task automatic rand_img();
        for (int i = 0; i < 784; i++) begin
            img[i] = int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 3) == 0) img[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_frame(input int gap_at);
        drive_weights();
        for (int i = 0; i < 784; i++) begin
            @(negedge clk);
            if (i == gap_at) begin
                feature_in_valid = 1'b0;
                repeat (10) begin
                    in_feature = 8'($urandom);
                    @(negedge clk);
                end
            end
            feature_in_valid = 1'b1;
            in_feature = 8'(img[i]);
        end
        @(negedge clk);
        feature_in_valid = 1'b0;
        in_feature = 8'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 25000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (out_valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL timeout out_valid=%b after %0d cycles", out_valid, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        total++;
        if (out_feature !== '0) begin
            bad++;
            $display("FAIL reset_out got nonzero want=0");
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_image();
        do_reset();
        set_raster();
        for (int k = 0; k < 25; k++) kv[k] = int'($urandom_range(0, 255)) - 128;
        fill_img(0);
        nreq = 25;
        load_frame(-1);
        wait_done(lat);
        total++;
        if (lat !== exp_latency()) begin
            bad++;
            $display("FAIL zero_lat got=%0d want=%0d", lat, exp_latency());
        end
        for (int i = 0; i < 576; i++) begin
            total++;
            if (out_feature[16*i +: 16] !== 16'h0000) begin
                bad++;
                $display("FAIL zero idx=%0d got=%h want=0000",
                         i, out_feature[16*i +: 16]);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        set_raster();
        for (int k = 1; k < 24; k++) kv[k] = int'($urandom_range(0, 255)) - 128;
        kv[0]  = 1;
        kv[24] = 8;
        fill_img(0);
        img[0] = 1;
        img[4*28 + 4] = 2;
        nreq = 25;
        model();
        load_frame(-1);
        wait_done(lat);
        total++;
        if (lat !== exp_latency()) begin
            bad++;
            $display("FAIL single_lat got=%0d want=%0d", lat, exp_latency());
        end
        for (int i = 0; i < 576; i++) begin
            total++;
            if (out_feature[16*i +: 16] !== expv[i]) begin
                bad++;
                $display("FAIL single idx=%0d got=%h want=%h",
                         i, out_feature[16*i +: 16], expv[i]);
            end
        end
        total++;
        if (out_feature[15:0] !== 16'h0011) begin
            bad++;
            $display("FAIL single_out0 got=%h want=0011", out_feature[15:0]);
        end
        total++;
        if (out_feature[1600 +: 16] !== 16'h0002) begin
            bad++;
            $display("FAIL single_out100 got=%h want=0002", out_feature[1600 +: 16]);
        end
        // DONE must ignore further pixel traffic
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            feature_in_valid = 1'b1;
            in_feature = 8'($urandom);
        end
        @(negedge clk);
        feature_in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_feature[15:0] !== 16'h0011) begin
            bad++;
            $display("FAIL done_hold valid=%b out0=%h want=1/0011",
                     out_valid, out_feature[15:0]);
        end
    endtask

    task automatic test_ones_nv40();
        int lst [25] = '{8, 9, 3, 2, -3, 5, 9, 9, 8, 1, -1, -1, 3,
                         7, 6, -11, -4, -4, 2, 4, -7, -8, -3, -1, 1};
        do_reset();
        set_raster();
        for (int i = 0; i < 25; i++) kv[24 - i] = lst[i];
        for (int k = 25; k < 28; k++) kv[k] = int'($urandom_range(1, 127));
        fill_img(1);
        nreq = 40;
        load_frame(-1);
        wait_done(lat);
        total++;
        if (lat !== exp_latency()) begin
            bad++;
            $display("FAIL ones_lat got=%0d want=%0d", lat, exp_latency());
        end
        for (int i = 0; i < 576; i++) begin
            total++;
            if (out_feature[16*i +: 16] !== 16'h0022) begin
                bad++;
                $display("FAIL ones idx=%0d got=%h want=0022",
                         i, out_feature[16*i +: 16]);
            end
        end
    endtask

    task automatic test_nv_edges();
        do_reset();
        set_raster();
        for (int k = 0; k < 28; k++) kv[k] = int'($urandom_range(1, 127));
        rand_img();
        nreq = 0;
        load_frame(-1);
        wait_done(lat);
        total++;
        if (lat !== 785) begin
            bad++;
            $display("FAIL nv0_lat got=%0d want=785", lat);
        end
        for (int i = 0; i < 576; i++) begin
            total++;
            if (out_feature[16*i +: 16] !== 16'h0000) begin
                bad++;
                $display("FAIL nv0 idx=%0d got=%h want=0000",
                         i, out_feature[16*i +: 16]);
            end
        end
        do_reset();
        set_raster();
        kv[0] = 3;
        kv[1] = 5;
        fill_img(1);
        nreq = 1;
        load_frame(-1);
        wait_done(lat);
        for (int i = 0; i < 576; i++) begin
            total++;
            if (out_feature[16*i +: 16] !== 16'h0003) begin
                bad++;
                $display("FAIL nv1 idx=%0d got=%h want=0003",
                         i, out_feature[16*i +: 16]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_raster();
        kv[0] = -128;
        kv[1] = -128;
        fill_img(-128);
        nreq = 2;
        load_frame(-1);
        wait_done(lat);
        for (int i = 0; i < 576; i++) begin
            total++;
            if (out_feature[16*i +: 16] !== 16'h8000) begin
                bad++;
                $display("FAIL wrap2 idx=%0d got=%h want=8000",
                         i, out_feature[16*i +: 16]);
            end
        end
        do_reset();
        set_raster();
        kv[0] = 127;
        fill_img(-128);
        nreq = 1;
        load_frame(-1);
        wait_done(lat);
        for (int i = 0; i < 576; i++) begin
            total++;
            if (out_feature[16*i +: 16] !== 16'hC080) begin
                bad++;
                $display("FAIL wrap1 idx=%0d got=%h want=c080",
                         i, out_feature[16*i +: 16]);
            end
        end
    endtask

    task automatic rand_kernel(input int n);
        for (int k = 0; k < 28; k++) begin
            kv[k]  = int'($urandom_range(0, 255)) - 128;
            kdx[k] = int'($urandom_range(0, 6));
            kdy[k] = int'($urandom_range(0, 6));
        end
        nreq = n;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rand_kernel(3);
        rand_img();
        load_frame(-1);
        repeat (200) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_valid got=%b want=0", out_valid);
        end
        total++;
        if (out_feature !== '0) begin
            bad++;
            $display("FAIL midrst_out got nonzero want=0");
        end
        @(negedge clk);
        rst = 1'b0;
        rand_kernel(3);
        rand_img();
        model();
        load_frame(300);
        wait_done(lat);
        total++;
        if (lat !== exp_latency()) begin
            bad++;
            $display("FAIL fresh_lat got=%0d want=%0d", lat, exp_latency());
        end
        for (int i = 0; i < 576; i++) begin
            total++;
            if (out_feature[16*i +: 16] !== expv[i]) begin
                bad++;
                $display("FAIL fresh idx=%0d got=%h want=%h",
                         i, out_feature[16*i +: 16], expv[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_image();
        test_single();
        test_ones_nv40();
        test_nv_edges();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
